// File: rtl/mips_exec_alu.sv
// Execute-stage ALU of the multi-cycle MIPS-I CPU.
// Combinational result/branch flag plus the HI/LO register pair.
module mips_exec_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  alu_control,
    input  logic [31:0] alu_src_1,
    input  logic [31:0] alu_src_2,
    output logic [31:0] alu_result,
    output logic        branch
);

    localparam logic [5:0] OP_SLL   = 6'h00;
    localparam logic [5:0] OP_SRL   = 6'h02;
    localparam logic [5:0] OP_SRA   = 6'h03;
    localparam logic [5:0] OP_SLLV  = 6'h04;
    localparam logic [5:0] OP_SRLV  = 6'h06;
    localparam logic [5:0] OP_SRAV  = 6'h07;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;
    localparam logic [5:0] OP_ADD   = 6'h20;
    localparam logic [5:0] OP_ADDU  = 6'h21;
    localparam logic [5:0] OP_SUB   = 6'h22;
    localparam logic [5:0] OP_SUBU  = 6'h23;
    localparam logic [5:0] OP_AND   = 6'h24;
    localparam logic [5:0] OP_OR    = 6'h25;
    localparam logic [5:0] OP_XOR   = 6'h26;
    localparam logic [5:0] OP_NOR   = 6'h27;
    localparam logic [5:0] OP_SLT   = 6'h2A;
    localparam logic [5:0] OP_SLTU  = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h30;
    localparam logic [5:0] OP_BNE   = 6'h31;
    localparam logic [5:0] OP_BLEZ  = 6'h32;
    localparam logic [5:0] OP_BGTZ  = 6'h33;
    localparam logic [5:0] OP_BLTZ  = 6'h34;
    localparam logic [5:0] OP_BGEZ  = 6'h35;

    logic [31:0] hi, lo;
    logic [4:0]  shamt;
    logic [31:0] sra_val;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [31:0] q_mag, r_mag;
    logic [31:0] q_s, r_s;
    logic [31:0] q_u, r_u;
    logic        div_ok;
    logic        a_zero;

    assign shamt   = alu_src_1[4:0];
    assign sra_val = $signed(alu_src_2) >>> shamt;

    // Sign-extend to 64 bits so the low 64 product bits are the signed product
    assign prod_s = {{32{alu_src_1[31]}}, alu_src_1}
                  * {{32{alu_src_2[31]}}, alu_src_2};
    assign prod_u = {32'h0, alu_src_1} * {32'h0, alu_src_2};

    // Signed divide via magnitudes: truncation toward zero falls out,
    // and 0x80000000 / -1 yields 0x80000000 rem 0 without a special case
    assign a_neg  = alu_src_1[31];
    assign b_neg  = alu_src_2[31];
    assign abs_a  = a_neg ? (32'h0 - alu_src_1) : alu_src_1;
    assign abs_b  = b_neg ? (32'h0 - alu_src_2) : alu_src_2;
    assign div_ok = (alu_src_2 != 32'h0);
    assign q_mag  = div_ok ? abs_a / abs_b : 32'h0;
    assign r_mag  = div_ok ? abs_a % abs_b : 32'h0;
    assign q_s    = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
    assign r_s    = a_neg ? (32'h0 - r_mag) : r_mag;
    assign q_u    = div_ok ? alu_src_1 / alu_src_2 : 32'h0;
    assign r_u    = div_ok ? alu_src_1 % alu_src_2 : 32'h0;
    assign a_zero = (alu_src_1 == 32'h0);

    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            OP_SLL, OP_SLLV: alu_result = alu_src_2 << shamt;
            OP_SRL, OP_SRLV: alu_result = alu_src_2 >> shamt;
            OP_SRA, OP_SRAV: alu_result = sra_val;
            OP_LUI:          alu_result = {alu_src_2[15:0], 16'h0000};
            OP_MFHI:         alu_result = hi;
            OP_MFLO:         alu_result = lo;
            OP_ADD, OP_ADDU: alu_result = alu_src_1 + alu_src_2;
            OP_SUB, OP_SUBU: alu_result = alu_src_1 - alu_src_2;
            OP_AND:          alu_result = alu_src_1 & alu_src_2;
            OP_OR:           alu_result = alu_src_1 | alu_src_2;
            OP_XOR:          alu_result = alu_src_1 ^ alu_src_2;
            OP_NOR:          alu_result = ~(alu_src_1 | alu_src_2);
            OP_SLT:
                alu_result = {31'h0,
                    $signed(alu_src_1) < $signed(alu_src_2)};
            OP_SLTU:
                alu_result = {31'h0, alu_src_1 < alu_src_2};
            default:         alu_result = 32'h0;
        endcase
    end

    always_comb begin
        branch = 1'b0;
        case (alu_control)
            OP_BEQ:  branch = (alu_src_1 == alu_src_2);
            OP_BNE:  branch = (alu_src_1 != alu_src_2);
            OP_BLEZ: branch = a_neg | a_zero;
            OP_BGTZ: branch = ~a_neg & ~a_zero;
            OP_BLTZ: branch = a_neg;
            OP_BGEZ: branch = ~a_neg;
            default: branch = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else begin
            case (alu_control)
                OP_MTHI:  hi <= alu_src_1;
                OP_MTLO:  lo <= alu_src_1;
                OP_MULT:  {hi, lo} <= prod_s;
                OP_MULTU: {hi, lo} <= prod_u;
                OP_DIV: begin
                    if (div_ok) begin
                        lo <= q_s;
                        hi <= r_s;
                    end
                end
                OP_DIVU: begin
                    if (div_ok) begin
                        lo <= q_u;
                        hi <= r_u;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_exec_alu.sv
// Directed self-checking bench for mips_exec_alu.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mips_exec_alu;

    logic        clk;
    logic        reset;
    logic [5:0]  alu_control;
    logic [31:0] alu_src_1;
    logic [31:0] alu_src_2;
    logic [31:0] alu_result;
    logic        branch;

    int checks = 0;
    int errors = 0;

    mips_exec_alu dut (
        .clk         (clk),
        .reset       (reset),
        .alu_control (alu_control),
        .alu_src_1   (alu_src_1),
        .alu_src_2   (alu_src_2),
        .alu_result  (alu_result),
        .branch      (branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [5:0] c,
                      input logic [31:0] a,
                      input logic [31:0] b);
        @(negedge clk);
        alu_control = c;
        alu_src_1   = a;
        alu_src_2   = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        alu_control = 6'h3F;
        alu_src_1   = 32'h0;
        alu_src_2   = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        op(6'h10, 0, 0);
        check("reset_hi", alu_result, 32'h0);
        op(6'h12, 0, 0);
        check("reset_lo", alu_result, 32'h0);

        op(6'h21, 32'h7FFFFFFF, 32'h1);
        check("addu_wrap", alu_result, 32'h80000000);
        op(6'h23, 32'h0, 32'h1);
        check("subu_neg", alu_result, 32'hFFFFFFFF);
        op(6'h27, 32'h0, 32'h0);
        check("nor_zero", alu_result, 32'hFFFFFFFF);
        op(6'h0F, 32'h0, 32'hFFFF1234);
        check("lui", alu_result, 32'h12340000);
        op(6'h24, 32'hF0F0FF00, 32'h0FF0F0F0);
        check("and", alu_result, 32'h00F0F000);
        op(6'h26, 32'hF0F0FF00, 32'h0FF0F0F0);
        check("xor", alu_result, 32'hFF000FF0);

        op(6'h03, 32'd31, 32'h80000000);
        check("sra31", alu_result, 32'hFFFFFFFF);
        op(6'h02, 32'd31, 32'h80000000);
        check("srl31", alu_result, 32'h00000001);
        op(6'h04, 32'h21, 32'h1);
        check("sllv_mask", alu_result, 32'h2);
        op(6'h07, 32'd4, 32'hF0000000);
        check("srav", alu_result, 32'hFF000000);

        op(6'h2A, 32'hFFFFFFFF, 32'h1);
        check("slt", alu_result, 32'h1);
        op(6'h2B, 32'hFFFFFFFF, 32'h1);
        check("sltu", alu_result, 32'h0);

        op(6'h30, 32'h5, 32'h5);
        check("beq_br", {31'h0, branch}, 32'h1);
        check("beq_res", alu_result, 32'h0);
        op(6'h31, 32'h5, 32'h5);
        check("bne_br", {31'h0, branch}, 32'h0);
        op(6'h35, 32'h0, 32'h0);
        check("bgez_0", {31'h0, branch}, 32'h1);
        op(6'h34, 32'h0, 32'h0);
        check("bltz_0", {31'h0, branch}, 32'h0);
        op(6'h32, 32'h0, 32'h0);
        check("blez_0", {31'h0, branch}, 32'h1);
        op(6'h33, 32'h0, 32'h0);
        check("bgtz_0", {31'h0, branch}, 32'h0);
        op(6'h33, 32'h80000000, 32'h0);
        check("bgtz_neg", {31'h0, branch}, 32'h0);
        op(6'h20, 32'h3, 32'h4);
        check("add_res", alu_result, 32'h7);
        check("add_nobr", {31'h0, branch}, 32'h0);

        op(6'h18, 32'hFFFFFFFE, 32'h3);
        check("mult_res", alu_result, 32'h0);
        tick();
        op(6'h10, 0, 0);
        check("mult_hi", alu_result, 32'hFFFFFFFF);
        op(6'h12, 0, 0);
        check("mult_lo", alu_result, 32'hFFFFFFFA);

        op(6'h19, 32'hFFFFFFFE, 32'h3);
        tick();
        op(6'h10, 0, 0);
        check("multu_hi", alu_result, 32'h00000002);
        op(6'h12, 0, 0);
        check("multu_lo", alu_result, 32'hFFFFFFFA);

        op(6'h1A, 32'hFFFFFFF9, 32'h2);
        tick();
        op(6'h12, 0, 0);
        check("div_lo", alu_result, 32'hFFFFFFFD);
        op(6'h10, 0, 0);
        check("div_hi", alu_result, 32'hFFFFFFFF);

        op(6'h1B, 32'h7, 32'h0);
        tick();
        op(6'h12, 0, 0);
        check("divu0_lo", alu_result, 32'hFFFFFFFD);
        op(6'h10, 0, 0);
        check("divu0_hi", alu_result, 32'hFFFFFFFF);

        op(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        tick();
        op(6'h12, 0, 0);
        check("divovf_lo", alu_result, 32'h80000000);
        op(6'h10, 0, 0);
        check("divovf_hi", alu_result, 32'h0);

        op(6'h1B, 32'd100, 32'd7);
        tick();
        op(6'h12, 0, 0);
        check("divu_lo", alu_result, 32'd14);
        op(6'h10, 0, 0);
        check("divu_hi", alu_result, 32'd2);

        op(6'h3F, 32'h12345678, 32'h9ABCDEF0);
        check("undef_res", alu_result, 32'h0);
        check("undef_br", {31'h0, branch}, 32'h0);
        tick();
        op(6'h12, 0, 0);
        check("undef_lo", alu_result, 32'd14);

        op(6'h11, 32'hDEADBEEF, 32'h0);
        tick();
        op(6'h10, 0, 0);
        check("mthi", alu_result, 32'hDEADBEEF);

        reset = 1'b1;
        op(6'h21, 32'h1, 32'h2);
        check("rst_comb", alu_result, 32'h3);
        op(6'h13, 32'hCAFEF00D, 32'h0);
        tick();
        reset = 1'b0;
        op(6'h10, 0, 0);
        check("rst_hi", alu_result, 32'h0);
        op(6'h12, 0, 0);
        check("rst_lo", alu_result, 32'h0);

        op(6'h13, 32'h55, 32'h0);
        tick();
        op(6'h12, 0, 0);
        check("mtlo", alu_result, 32'h55);
        op(6'h13, 32'h66, 32'h0);
        check("mtlo_res", alu_result, 32'h0);
        tick();
        op(6'h12, 0, 0);
        check("mtlo_new", alu_result, 32'h66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_exec_alu.md
# mips_exec_alu

Execute-stage arithmetic unit of the multi-cycle MIPS-I bus CPU. Combinationally computes the 32-bit result for ALU, shift, compare, set and LUI operations and the branch-taken flag for conditional branches. Owns the architectural HI/LO registers, which are written on the clock edge by multiply, divide and move-to operations. Sits between the operand multiplexers (rs/shamt/memory word on src1, rt/sign-extended immediate on src2) and the write-back/address/PC logic.

## Interface
- No parameters.
- clk  input  1  system clock; HI/LO update on rising edge.
- reset  input  1  synchronous, active-high; clears HI and LO.
- alu_control  input  6  operation select (encoding below).
- alu_src_1  input  32  operand A: rs value, or shift amount in bits [4:0].
- alu_src_2  input  32  operand B: rt value or extended immediate.
- alu_result  output  32  combinational result.
- branch  output  1  combinational branch-condition flag.

## Operation
- Shifts (value = src2, amount = src1[4:0]): 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV. SRA/SRAV replicate src2[31].
- 0x0F LUI: result = {src2[15:0], 16'h0000}.
- 0x20 ADD, 0x21 ADDU: src1+src2 modulo 2^32; no overflow trap.
- 0x22 SUB, 0x23 SUBU: src1-src2 modulo 2^32; no trap.
- 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise.
- 0x2A SLT: result = 1 if signed src1 < src2, else 0. 0x2B SLTU: unsigned compare.
- 0x10 MFHI: result = HI. 0x12 MFLO: result = LO.
- 0x11 MTHI: HI <= src1. 0x13 MTLO: LO <= src1. result = 0.
- 0x18 MULT / 0x19 MULTU: 64-bit signed/unsigned product; {HI,LO} <= product. result = 0.
- 0x1A DIV / 0x1B DIVU: LO <= quotient, HI <= remainder, signed/unsigned. Signed quotient truncates toward zero; remainder takes sign of dividend. 0x80000000 / -1: LO = 0x80000000, HI = 0. Divisor 0: HI and LO unchanged. result = 0.
- Branch compares (result = 0): 0x30 BEQ src1==src2; 0x31 BNE src1!=src2; 0x32 BLEZ signed src1<=0; 0x33 BGTZ signed src1>0; 0x34 BLTZ src1[31]==1; 0x35 BGEZ src1[31]==0.
- branch = 0 for every non-branch code.
- Undefined codes: result = 0, branch = 0, HI/LO unchanged.

## Timing
- alu_result and branch are purely combinational from alu_control, operands and current HI/LO; zero-cycle latency.
- HI/LO are written on every rising clk edge at which a writing code (0x11, 0x13, 0x18-0x1B) is present and reset is low. Repeated presentation with stable operands is idempotent; the controller may hold a code across several cycles.
- MFHI/MFLO in the same cycle as a HI/LO write return the old value; the new value is visible the cycle after the edge.
- reset high at a rising edge: HI = LO = 0x00000000, regardless of alu_control; reset takes priority over any write in that cycle. Combinational outputs are not gated by reset.
- Reset mid-multiply/divide discards the operation (single-cycle, no partial state).

## Test plan
- ADDU 0x7FFFFFFF + 1 -> 0x80000000; SUBU 0 - 1 -> 0xFFFFFFFF; NOR 0,0 -> 0xFFFFFFFF; LUI src2=0x1234 -> 0x12340000.
- SRA src2=0x80000000, src1=31 -> 0xFFFFFFFF; SRL same -> 0x00000001; SLLV src1=0x21 (amount 1), src2=1 -> 2.
- SLT src1=0xFFFFFFFF, src2=1 -> 1; SLTU same -> 0; BEQ equal -> branch=1; BGEZ src1=0 -> 1; BLTZ src1=0 -> 0; ADD code -> branch=0.
- MULT 0xFFFFFFFE x 3, clock, MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFFA; MULTU same -> HI 0x00000002, LO 0xFFFFFFFA.
- DIV -7 / 2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged; DIV 0x80000000 / -1 -> LO 0x80000000, HI 0.
- MTHI 0xDEADBEEF then reset for one edge -> MFHI = 0; MTLO with reset high -> LO stays 0; MFLO same cycle as MTLO returns prior LO.
